// File: rtl/wide_add_seq_if.sv
// Start/busy/done bus for wide_add_seq; the sub line exists only when SUB_EN is defined.
interface wide_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int N = 32 * WORDS;

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
`ifdef SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

`ifdef SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/wide_add_seq.sv
// Word-serial WORDS*32-bit adder built on one 32-bit slice, LSW first, carry registered.
// Optional feature macro SUB_EN adds a sub input for A-B (two's complement, cout = not-borrow).
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input logic          clk,
  input logic          rst,
  wide_add_seq_if.slave bus
);
  localparam int N    = 32 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_r;
  logic [IDXW-1:0] idx_r;
  logic            carry_r;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [N-1:0]    sum_r;
  logic            cout_r;
  logic            busy_r;
  logic            done_r;

  logic            sub_s;
  logic [31:0]     a_word_s;
  logic [31:0]     b_word_s;
  logic [32:0]     word_sum_s;
  logic            last_word_s;

  // Shared slice: widen to 33 bits before adding so the carry is never truncated.
  always_comb begin
`ifdef SUB_EN
    sub_s       = bus.sub;
`else
    sub_s       = 1'b0;
`endif
    a_word_s    = a_r[{idx_r, 5'b00000} +: 32];
    b_word_s    = b_r[{idx_r, 5'b00000} +: 32];
    word_sum_s  = {1'b0, a_word_s} + {1'b0, b_word_s} + {32'd0, carry_r};
    last_word_s = (idx_r == IDXW'(WORDS - 1));
  end

  // Sequencer state, operand capture and word-by-word result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            // Subtraction is A + ~B + 1, so the inverted operand and initial carry come from sub.
            b_r     <= sub_s ? ~bus.b : bus.b;
            carry_r <= sub_s;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
          end
          done_r <= 1'b0;
        end
        ST_RUN: begin
          sum_r[{idx_r, 5'b00000} +: 32] <= word_sum_s[31:0];
          carry_r <= word_sum_s[32];
          if (last_word_s) begin
            cout_r  <= word_sum_s[32];
            idx_r   <= '0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + IDXW'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq with WORDS=4 (128-bit operands).
module tb_wide_add_seq;
  localparam int WORDS = 4;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  wide_add_seq_if #(.WORDS(WORDS)) bus ();
  wide_add_seq #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; optionally a second start (rejected) at cycle rej_at after the accepted edge.
  task automatic do_op(input logic [127:0] av, input logic [127:0] bv, input logic sv,
                       input int rej_at, output int lat, output int npulse,
                       output logic [127:0] rsum, output logic rcout, output logic busy_after);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
`ifdef SUB_EN
    bus.sub = sv;
`endif
    tick();
    bus.start = 1'b0; bus.a = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA; bus.b = ONES;
    lat = -1; npulse = 0; rsum = '0; rcout = 1'b0; busy_after = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) begin
        npulse++;
        if (lat < 0) begin lat = k; rsum = bus.sum; rcout = bus.cout; end
      end
      if (lat >= 0 && k == lat + 1) busy_after = bus.busy;
      if (k == rej_at) begin bus.start = 1'b1; bus.a = 128'd9; bus.b = 128'd9; end
      else bus.start = 1'b0;
      tick();
    end
  endtask

  int lat, np;
  logic [127:0] rs;
  logic rc, ba;

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
`ifdef SUB_EN
    bus.sub = 1'b0;
`endif
    // 1 reset
    tick(); tick();
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_sum",  bus.sum, 128'd0);
    check_eq("rst_cout", bus.cout, 1'b0);
    rst = 1'b0;
    tick(); tick(); tick();
    check_eq("idle_busy", bus.busy, 1'b0);
    check_eq("idle_sum",  bus.sum, 128'd0);

    // 2 carry across words
    do_op(128'hFFFF_FFFF, 128'd1, 1'b0, -1, lat, np, rs, rc, ba);
    check_eq("carry_lat",   32'(lat), 32'd4);
    check_eq("carry_pulse", 32'(np), 32'd1);
    check_eq("carry_sum",   rs, 128'h1_0000_0000);
    check_eq("carry_cout",  rc, 1'b0);
    check_eq("carry_hold",  bus.sum, 128'h1_0000_0000);

    // 3 full wrap, then carry cleared between ops
    do_op(ONES, 128'd1, 1'b0, -1, lat, np, rs, rc, ba);
    check_eq("wrap_sum",  rs, 128'd0);
    check_eq("wrap_cout", rc, 1'b1);
    check_eq("wrap_hold_cout", bus.cout, 1'b1);
    do_op(128'd3, 128'd4, 1'b0, -1, lat, np, rs, rc, ba);
    check_eq("clr_sum",  rs, 128'd7);
    check_eq("clr_cout", rc, 1'b0);

    // 4 busy reject: second start two cycles later
    do_op(128'd1, 128'd2, 1'b0, 1, lat, np, rs, rc, ba);
    check_eq("rej_pulse", 32'(np), 32'd1);
    check_eq("rej_lat",   32'(lat), 32'd4);
    check_eq("rej_sum",   rs, 128'd3);
    check_eq("rej_busy_after", ba, 1'b0);

    // 5 abort: reset during the second RUN cycle
    bus.start = 1'b1; bus.a = ONES; bus.b = ONES;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_sum",  bus.sum, 128'd0);
    np = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) np++;
      tick();
    end
    check_eq("abort_nodone", 32'(np), 32'd0);
    do_op(128'd5, 128'd6, 1'b0, -1, lat, np, rs, rc, ba);
    check_eq("abort_fresh_sum", rs, 128'd11);
    check_eq("abort_fresh_cout", rc, 1'b0);

`ifdef SUB_EN
    // 6 subtract
    do_op(128'd5, 128'd3, 1'b1, -1, lat, np, rs, rc, ba);
    check_eq("sub_sum",  rs, 128'd2);
    check_eq("sub_cout", rc, 1'b1);
    do_op(128'd0, 128'd1, 1'b1, -1, lat, np, rs, rc, ba);
    check_eq("sub_borrow_sum",  rs, ONES);
    check_eq("sub_borrow_cout", rc, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
